multi_tick_generator: RTL and testbench
=======================================

MULTI_TICK_GENERATOR -- requirements
Module: multi_tick_generator

Interface
REQ-001 Parameter NR_BITS, default 16: width of each channel counter and reload value.
REQ-002 Parameter NR_CHANNELS, default 4: number of independent tick channels, legal range 1..16.
REQ-003 Parameter DEFAULT_RELOAD, default 10: reload value of every channel after reset.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 FPGAClock  in  1  sole clock, all state updates on its rising edge.
REQ-006 FPGAReset  in  1  synchronous, active-high reset.
REQ-007 enable  in  NR_CHANNELS  per-channel count enable.
REQ-008 sync  in  1  restart all channels in phase.
REQ-009 cfg_valid  in  1  reload-write request.
REQ-010 cfg_ready  out  1  reload-write accept; transfer occurs when cfg_valid and cfg_ready are both high.
REQ-011 cfg_channel  in  CH_W = max(1, clog2(NR_CHANNELS))  target channel.
REQ-012 cfg_reload  in  NR_BITS  new reload value.
REQ-013 FPGATick  out  NR_CHANNELS  registered one-cycle tick pulse per channel.

Function
REQ-014 Each channel SHALL hold a count register, an active reload register, a shadow reload register and a pending flag.
REQ-015 Enabled channel: count==0 -> next FPGATick=1, count=active_reload-1; else count-1, FPGATick=0.
REQ-016 Tick latency: FPGATick SHALL assert in the cycle after the cycle in which count==0 is observed.
REQ-017 Period: FPGATick SHALL assert once every active_reload enabled cycles, with active_reload 0 treated as 1 (tick every enabled cycle).
REQ-018 Disabled channel: count SHALL hold its value and FPGATick SHALL be 0.
REQ-019 cfg_ready SHALL equal NOT pending[cfg_channel] and SHALL be 0 during reset.
REQ-020 Accepted write: shadow is loaded and the pending flag is set.
REQ-021 Out-of-range channel (cfg_channel >= NR_CHANNELS): cfg_ready=1, write discarded.
REQ-022 Commit (shadow->active, pending cleared) SHALL occur at the channel's next wrap (count==0 while enabled), or in the next cycle if the channel is disabled, so that no truncated period is produced.
REQ-023 sync=1: all counts SHALL become 0, FPGATick SHALL be all 0 that cycle, and all pending shadows SHALL commit.
REQ-024 Priority: reset > sync > commit/decrement; a write accepted in the same cycle as sync SHALL commit at the following wrap.
REQ-025 Counter arithmetic SHALL be modulo 2^NR_BITS; reload values wider than NR_BITS SHALL be impossible by construction.

Reset
REQ-026 On FPGAReset: count=0, active=shadow=DEFAULT_RELOAD, pending=0, FPGATick=0, cfg_ready=0.
REQ-027 First tick: an enabled channel SHALL tick in the 2nd cycle after reset release.
REQ-028 Reset asserted mid-period or mid-handshake SHALL discard any pending write.

Configuration
REQ-029 With macro TICK_GEN_CASCADE_EN defined, input cascade [NR_CHANNELS] SHALL exist.
REQ-030 With TICK_GEN_CASCADE_EN, channel i>0 with cascade[i]=1 SHALL advance only in cycles where enable[i] and FPGATick[i-1] are both 1; cascade[0] is ignored.
REQ-031 Without TICK_GEN_CASCADE_EN, the cascade port is absent and all channels count free-running on enable.

Structure
REQ-032 Package multi_tick_generator_pkg SHALL hold the CH_W helper function, the NR_CHANNELS limit constant (16) and the channel state record typedef.
REQ-033 Sub-module tick_channel SHALL implement one channel (count, active, shadow, pending, tick), instantiated NR_CHANNELS times by generate.

Verification
REQ-034 Reset, enable=all 1, DEFAULT_RELOAD=10 -> each FPGATick high in cycles 2, 12, 22 after reset release.
REQ-035 Write ch1 reload=3 mid-period -> old period completes, then ticks every 3 cycles; cfg_ready[ch1] low until commit.
REQ-036 enable[2]=0 for 5 cycles mid-count -> tick delayed exactly 5 cycles; reload 0 -> tick every enabled cycle.
REQ-037 sync pulse with channels out of phase -> all FPGATick low that cycle, then all high together 2 cycles after sync.
REQ-038 cfg_channel=7 with NR_CHANNELS=4 -> accepted, no reload changes; second write to a pending channel -> stalled until commit.
REQ-039 TICK_GEN_CASCADE_EN, ch0 reload 10, ch1 reload 6, cascade[1]=1 -> ch1 ticks every 60 cycles.

Source files
------------

// File: rtl/multi_tick_generator_pkg.sv
// multi_tick_generator_pkg: shared constants, helper function and types
// for the multi-channel tick generator.
package multi_tick_generator_pkg;

    // Largest channel count the generator supports.
    localparam int MAX_CHANNELS = 16;

    // Width of the channel-select field; never narrower than one bit so a
    // single-channel build still has a legal port.
    function automatic int ch_width(input int nr_channels);
        return (nr_channels > 1) ? $clog2(nr_channels) : 1;
    endfunction

    // Single-bit state carried by every channel alongside its counters.
    typedef struct packed {
        logic pending;  // shadow reload waiting to become active
        logic tick;     // registered tick pulse
    } chan_status_t;

    // What a channel's counter does in a given cycle.
    typedef enum logic [1:0] {
        ACT_HOLD,  // not advancing: count frozen
        ACT_DEC,   // advancing, count non-zero: count down
        ACT_WRAP,  // advancing, count zero: tick and reload
        ACT_SYNC   // global restart: count cleared
    } chan_action_t;

endpackage : multi_tick_generator_pkg

// File: rtl/multi_tick_generator_if.sv
// multi_tick_generator_if: reload-write handshake. A write transfers when
// cfg_valid and cfg_ready are both high on a rising clock edge.
interface multi_tick_generator_if #(
    parameter int CH_W    = 2,
    parameter int NR_BITS = 16
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [CH_W-1:0]    cfg_channel;
    logic [NR_BITS-1:0] cfg_reload;

    // Side issuing reload writes.
    modport master (
        output cfg_valid,
        output cfg_channel,
        output cfg_reload,
        input  cfg_ready
    );

    // Side accepting reload writes (the generator).
    modport slave (
        input  cfg_valid,
        input  cfg_channel,
        input  cfg_reload,
        output cfg_ready
    );
endinterface : multi_tick_generator_if

// File: rtl/tick_channel.sv
// tick_channel: one down-counting tick channel with a double-buffered
// reload value. A new reload sits in the shadow register (pending) until the
// channel wraps, is disabled, or is synced, so a period is never truncated.
module tick_channel
    import multi_tick_generator_pkg::*;
#(
    parameter int NR_BITS        = 16,
    parameter int DEFAULT_RELOAD = 10
) (
    input  logic               clk_i,
    input  logic               rst_i,        // synchronous, active-high
    input  logic               advance_i,    // count this cycle
    input  logic               enable_i,     // channel enable (commit when low)
    input  logic               sync_i,       // global in-phase restart
    input  logic               wr_en_i,      // accepted reload write
    input  logic [NR_BITS-1:0] wr_reload_i,
    output logic               tick_o,
    output logic               pending_o
);

    localparam logic [NR_BITS-1:0] RESET_RELOAD = NR_BITS'(DEFAULT_RELOAD);

    logic [NR_BITS-1:0] count_q,  count_d;
    logic [NR_BITS-1:0] active_q, active_d;
    logic [NR_BITS-1:0] shadow_q, shadow_d;
    chan_status_t       status_q, status_d;
    chan_action_t       action;
    logic               commit;

    // Classify the counter action; sync outranks everything but reset.
    always_comb begin
        if (sync_i) begin
            action = ACT_SYNC;
        end else if (!advance_i) begin
            action = ACT_HOLD;
        end else if (count_q == '0) begin
            action = ACT_WRAP;
        end else begin
            action = ACT_DEC;
        end
    end

    // A pending reload goes live at a wrap, on sync, or as soon as the
    // channel is disabled (no period in flight to truncate).
    assign commit = status_q.pending &&
                    (action == ACT_SYNC || action == ACT_WRAP || !enable_i);

    // Next-state for counter, reload registers and status flags.
    always_comb begin
        // NOTE: every target gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        count_d         = count_q;
        active_d        = active_q;
        shadow_d        = shadow_q;
        status_d        = status_q;
        status_d.tick   = 1'b0;

        if (commit) begin
            active_d         = shadow_q;
            status_d.pending = 1'b0;
        end

        // A write is only accepted while nothing is pending, so it never
        // collides with a commit in the same cycle.
        if (wr_en_i) begin
            shadow_d         = wr_reload_i;
            status_d.pending = 1'b1;
        end

        unique case (action)
            ACT_SYNC: count_d = '0;
            ACT_WRAP: begin
                // Reload from the value in effect after this cycle's commit;
                // a reload of 0 behaves as 1 (tick every advancing cycle).
                count_d       = (active_d == '0) ? '0 : active_d - NR_BITS'(1);
                status_d.tick = 1'b1;
            end
            ACT_DEC:  count_d = count_q - NR_BITS'(1);
            default:  count_d = count_q;
        endcase
    end

    // Channel state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst_i) begin
            count_q  <= '0;
            active_q <= RESET_RELOAD;
            shadow_q <= RESET_RELOAD;
            status_q <= '0;
        end else begin
            count_q  <= count_d;
            active_q <= active_d;
            shadow_q <= shadow_d;
            status_q <= status_d;
        end
    end

    assign tick_o    = status_q.tick;
    assign pending_o = status_q.pending;

endmodule : tick_channel

// File: rtl/multi_tick_generator.sv
// multi_tick_generator: NR_CHANNELS independent programmable tick channels
// sharing one clock, a global sync and a reload-write handshake.
// Optional feature: define TICK_GEN_CASCADE_EN to add the cascade input,
// which lets channel i>0 count ticks of channel i-1 instead of clock cycles.
module multi_tick_generator
    import multi_tick_generator_pkg::*;
#(
    parameter int NR_BITS        = 16,
    parameter int NR_CHANNELS    = 4,
    parameter int DEFAULT_RELOAD = 10
) (
    input  logic                   FPGAClock,
    input  logic                   FPGAReset,
    input  logic [NR_CHANNELS-1:0] enable,
    input  logic                   sync,
`ifdef TICK_GEN_CASCADE_EN
    input  logic [NR_CHANNELS-1:0] cascade,
`endif
    multi_tick_generator_if.slave  cfg,
    output logic [NR_CHANNELS-1:0] FPGATick
);

    localparam int CH_W = ch_width(NR_CHANNELS);

    if (NR_CHANNELS < 1 || NR_CHANNELS > MAX_CHANNELS) begin : g_bad_channels
        $error("multi_tick_generator: NR_CHANNELS out of range 1..16");
    end

    logic [NR_CHANNELS-1:0] advance;
    logic [NR_CHANNELS-1:0] chan_pending;
    logic [NR_CHANNELS-1:0] wr_en;
    logic                   sel_pending;

    // Pending flag of the addressed channel; an out-of-range address matches
    // no channel, reads as not pending and its write is simply dropped.
    always_comb begin
        sel_pending = 1'b0;
        for (int i = 0; i < NR_CHANNELS; i++) begin
            if (int'(cfg.cfg_channel) == i) begin
                sel_pending = chan_pending[i];
            end
        end
    end

    assign cfg.cfg_ready = !FPGAReset && !sel_pending;

`ifdef TICK_GEN_CASCADE_EN
    // Channel 0 has no upstream neighbour, so its cascade bit has no effect.
    logic unused_cascade0;
    assign unused_cascade0 = cascade[0];
`endif

    for (genvar i = 0; i < NR_CHANNELS; i++) begin : g_chan
`ifdef TICK_GEN_CASCADE_EN
        if (i == 0) begin : g_head
            assign advance[i] = enable[i];
        end else begin : g_link
            assign advance[i] = enable[i] && (!cascade[i] || FPGATick[i-1]);
        end
`else
        assign advance[i] = enable[i];
`endif

        assign wr_en[i] = cfg.cfg_valid && cfg.cfg_ready &&
                          (int'(cfg.cfg_channel) == i);

        tick_channel #(
            .NR_BITS        (NR_BITS),
            .DEFAULT_RELOAD (DEFAULT_RELOAD)
        ) u_chan (
            .clk_i       (FPGAClock),
            .rst_i       (FPGAReset),
            .advance_i   (advance[i]),
            .enable_i    (enable[i]),
            .sync_i      (sync),
            .wr_en_i     (wr_en[i]),
            .wr_reload_i (cfg.cfg_reload),
            .tick_o      (FPGATick[i]),
            .pending_o   (chan_pending[i])
        );
    end

endmodule : multi_tick_generator

// File: tb/tb_multi_tick_generator.sv
// tb_multi_tick_generator: directed, scoreboarded bench for
// multi_tick_generator. A cycle model pushes the expected tick vector when
// inputs are applied; it is popped and compared after the clock edge.
// Cascade steps are compiled in when TICK_GEN_CASCADE_EN is defined.
`timescale 1ns/1ps
module tb_multi_tick_generator;
    import multi_tick_generator_pkg::*;

    localparam int NB  = 16;
    localparam int NC  = 4;
    localparam int NC2 = 5;
    localparam int CW  = ch_width(NC);
    localparam int CW2 = ch_width(NC2);

    logic           FPGAClock = 1'b0;
    logic           FPGAReset;
    logic [NC-1:0]  enable;
    logic           sync;
    logic [NC-1:0]  tick;
    logic [NC2-1:0] tick2;
`ifdef TICK_GEN_CASCADE_EN
    logic [NC-1:0]  cascade;
`endif

    multi_tick_generator_if #(.CH_W(CW),  .NR_BITS(NB)) cfg_if ();
    multi_tick_generator_if #(.CH_W(CW2), .NR_BITS(NB)) cfg_if2 ();

    always #5 FPGAClock = ~FPGAClock;

    multi_tick_generator #(.NR_BITS(NB), .NR_CHANNELS(NC), .DEFAULT_RELOAD(10)) dut (
        .FPGAClock (FPGAClock),
        .FPGAReset (FPGAReset),
        .enable    (enable),
        .sync      (sync),
`ifdef TICK_GEN_CASCADE_EN
        .cascade   (cascade),
`endif
        .cfg       (cfg_if),
        .FPGATick  (tick)
    );

    // Second instance: 5 channels, free-running, used for out-of-range writes.
    multi_tick_generator #(.NR_BITS(NB), .NR_CHANNELS(NC2), .DEFAULT_RELOAD(10)) dut2 (
        .FPGAClock (FPGAClock),
        .FPGAReset (FPGAReset),
        .enable    ({NC2{1'b1}}),
        .sync      (1'b0),
`ifdef TICK_GEN_CASCADE_EN
        .cascade   ({NC2{1'b0}}),
`endif
        .cfg       (cfg_if2),
        .FPGATick  (tick2)
    );

    // Reference model state
    logic [NB-1:0] m_count  [NC];
    logic [NB-1:0] m_active [NC];
    logic [NB-1:0] m_shadow [NC];
    logic [NC-1:0] m_pending;
    logic [NC-1:0] m_tick;
    logic [NC-1:0] exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;   // edges since last reset release
    int abs_cyc  = 0;   // edges since start
    int last_tick [NC];
    int gap       [NC];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_ready();
        if (FPGAReset) return 1'b0;
        if (int'(cfg_if.cfg_channel) >= NC) return 1'b1;
        return !m_pending[cfg_if.cfg_channel];
    endfunction

    // Predict the outcome of the coming edge from the inputs now applied.
    task automatic model_edge();
        logic [NC-1:0] nt;
        logic acc;
        logic adv;
        nt = '0;
        if (FPGAReset) begin
            for (int i = 0; i < NC; i++) begin
                m_count[i]  = '0;
                m_active[i] = NB'(10);
                m_shadow[i] = NB'(10);
            end
            m_pending = '0;
        end else begin
            acc = cfg_if.cfg_valid && model_ready();
            for (int i = 0; i < NC; i++) begin
                adv = enable[i];
`ifdef TICK_GEN_CASCADE_EN
                if (i > 0 && cascade[i]) adv = enable[i] && m_tick[i-1];
`endif
                if (sync) begin
                    if (m_pending[i]) begin
                        m_active[i]  = m_shadow[i];
                        m_pending[i] = 1'b0;
                    end
                    m_count[i] = '0;
                end else if (adv && m_count[i] == '0) begin
                    if (m_pending[i]) begin
                        m_active[i]  = m_shadow[i];
                        m_pending[i] = 1'b0;
                    end
                    nt[i]      = 1'b1;
                    m_count[i] = (m_active[i] == '0) ? '0 : m_active[i] - NB'(1);
                end else if (adv) begin
                    m_count[i] = m_count[i] - NB'(1);
                end else if (!enable[i] && m_pending[i]) begin
                    m_active[i]  = m_shadow[i];
                    m_pending[i] = 1'b0;
                end
                if (acc && int'(cfg_if.cfg_channel) == i) begin
                    m_shadow[i]  = cfg_if.cfg_reload;
                    m_pending[i] = 1'b1;
                end
            end
        end
        m_tick = nt;
        exp_q.push_back(nt);
    endtask

    // One clock: check handshake, predict, clock, compare outputs.
    task automatic step();
        logic [NC-1:0] exp_t;
        logic          was_rst;
        #1;
        check("cfg_ready", 32'(cfg_if.cfg_ready), 32'(model_ready()));
        was_rst = FPGAReset;
        model_edge();
        @(posedge FPGAClock);
        @(negedge FPGAClock);
        abs_cyc++;
        cyc = was_rst ? 0 : cyc + 1;
        exp_t = exp_q.pop_front();
        check("tick", 32'(tick), 32'(exp_t));
        for (int i = 0; i < NC; i++) begin
            if (tick[i] === 1'b1) begin
                gap[i]       = abs_cyc - last_tick[i];
                last_tick[i] = abs_cyc;
            end
        end
        check("tick2_free_run", 32'(tick2), (cyc % 10 == 1) ? 32'h1F : 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        FPGAReset = 1'b1;
        enable    = '1;
        sync      = 1'b0;
`ifdef TICK_GEN_CASCADE_EN
        cascade   = '0;
`endif
        cfg_if.cfg_valid   = 1'b0;
        cfg_if.cfg_channel = '0;
        cfg_if.cfg_reload  = '0;
        cfg_if2.cfg_valid   = 1'b0;
        cfg_if2.cfg_channel = '0;
        cfg_if2.cfg_reload  = '0;
        for (int i = 0; i < NC; i++) begin
            last_tick[i] = 0;
            gap[i]       = 0;
        end
        @(negedge FPGAClock);

        // Reset state
        repeat (3) step();
        check("ready_in_reset", 32'(cfg_if.cfg_ready), 32'h0);
        check("tick_in_reset", 32'(tick), 32'h0);

        // Default period: ticks 1, 11, 21 edges after release
        FPGAReset = 1'b0;
        for (int k = 0; k < 25; k++) begin
            step();
            check("tick_default", 32'(tick), (cyc == 1 || cyc == 11 || cyc == 21) ? 32'hF : 32'h0);
        end

        // Write ch1 reload 3 mid-period, then a stalled second write of 5
        cfg_if.cfg_valid   = 1'b1;
        cfg_if.cfg_channel = 2'd1;
        cfg_if.cfg_reload  = 16'd3;
        step();
        cfg_if.cfg_reload  = 16'd5;
        #1 check("ch1_stalled", 32'(cfg_if.cfg_ready), 32'h0);
        repeat (6) step();
        cfg_if.cfg_valid = 1'b0;
        check("ch1_old_period", gap[1], 10);
        repeat (3) step();
        check("ch1_period_3", gap[1], 3);
        repeat (10) step();
        check("ch1_period_5", gap[1], 5);

        // Disable ch2 for 5 cycles mid-count
        enable = 4'b1011;
        repeat (5) step();
        enable = 4'b1111;
        repeat (8) step();
        check("ch2_delayed_gap", gap[2], 15);

        // Reload 0 on ch2: tick every enabled cycle
        cfg_if.cfg_valid   = 1'b1;
        cfg_if.cfg_channel = 2'd2;
        cfg_if.cfg_reload  = 16'd0;
        step();
        cfg_if.cfg_valid = 1'b0;
        repeat (9) step();
        check("ch2_reload0_gap", gap[2], 1);

        // Write to disabled ch3 commits next cycle; out-of-range writes on dut2
        enable              = 4'b0111;
        cfg_if.cfg_valid    = 1'b1;
        cfg_if.cfg_channel  = 2'd3;
        cfg_if.cfg_reload   = 16'd7;
        cfg_if2.cfg_valid   = 1'b1;
        cfg_if2.cfg_channel = 3'd7;
        cfg_if2.cfg_reload  = 16'd2;
        #1 check("oor_ready_ch7", 32'(cfg_if2.cfg_ready), 32'h1);
        step();
        cfg_if.cfg_valid    = 1'b0;
        cfg_if2.cfg_channel = 3'd5;
        cfg_if2.cfg_reload  = 16'd3;
        #1 check("ch3_pending_ready", 32'(cfg_if.cfg_ready), 32'h0);
        check("oor_ready_ch5", 32'(cfg_if2.cfg_ready), 32'h1);
        step();
        cfg_if2.cfg_valid = 1'b0;
        #1 check("ch3_disabled_commit", 32'(cfg_if.cfg_ready), 32'h1);
        enable = 4'b1111;
        repeat (10) step();

        // Sync with channels out of phase; write ch0 in the same cycle
        sync               = 1'b1;
        cfg_if.cfg_valid   = 1'b1;
        cfg_if.cfg_channel = 2'd0;
        cfg_if.cfg_reload  = 16'd4;
        step();
        check("sync_ticks_low", 32'(tick), 32'h0);
        sync             = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        step();
        check("sync_all_high", 32'(tick), 32'hF);
        repeat (4) step();
        check("ch0_after_sync_gap", gap[0], 4);

        // Reset while ch1 write is pending discards it
        cfg_if.cfg_valid   = 1'b1;
        cfg_if.cfg_channel = 2'd1;
        cfg_if.cfg_reload  = 16'd20;
        step();
        cfg_if.cfg_valid = 1'b0;
        FPGAReset        = 1'b1;
        step();
        check("ready_mid_reset", 32'(cfg_if.cfg_ready), 32'h0);
        FPGAReset = 1'b0;
        #1 check("ready_after_reset", 32'(cfg_if.cfg_ready), 32'h1);
        step();
        check("first_tick_after_reset", 32'(tick), 32'hF);
        repeat (11) step();
        check("ch1_default_after_reset", gap[1], 10);
        check("ch0_default_after_reset", gap[0], 10);

`ifdef TICK_GEN_CASCADE_EN
        // Cascade: ch0 reload 10 drives ch1 reload 6 -> period 60
        cfg_if.cfg_valid   = 1'b1;
        cfg_if.cfg_channel = 2'd1;
        cfg_if.cfg_reload  = 16'd6;
        step();
        cfg_if.cfg_valid = 1'b0;
        repeat (12) step();
        cascade = 4'b0010;
        repeat (140) step();
        check("cascade_period_60", gap[1], 60);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_multi_tick_generator
